// File: rtl/search_sequencer_pkg.sv
// search_pkg: shared types and helpers for the search sequencer.
//   state_e            - sequencer state encoding
//   PIPE_DEPTH_DEFAULT - default hash-pipeline latency
//   WARM_W             - warm-up counter width (covers PIPE_DEPTH up to 64)
//   decode_target()    - 4-bit selector to target pattern (truncate to WIDTH)
package search_pkg;

  localparam int unsigned PIPE_DEPTH_DEFAULT = 4;
  localparam int unsigned WARM_W             = 7;

  typedef enum logic [2:0] {
    ST_PAUSED,
    ST_WARMING,
    ST_RUNNING,
    ST_FOUND,
    ST_DONE
  } state_e;

  function automatic logic [63:0] decode_target(input logic [3:0] sel);
    logic [63:0] t;
    case (sel)
      4'd0:    t = 64'h0;
      4'd1:    t = 64'h1;
      4'd2:    t = 64'h2;
      4'd3:    t = 64'h10;
      4'd4:    t = 64'h100;
      4'd5:    t = 64'h1000;
      4'd6:    t = 64'h1_0000;
      4'd7:    t = 64'h10_0000;
      4'd8:    t = 64'h100_0000;
      4'd9:    t = 64'h1000_0000;
      default: t = '1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/search_sequencer_if.sv
// search_sequencer_if: candidate/result bus between sequencer and hash pipeline.
//   cand_valid/cand_value   - candidate issued this cycle (sequencer -> pipeline)
//   target_value            - latched target for the compare stage
//   res_valid/res_value     - result strobe and echoed candidate (pipeline -> sequencer)
//   res_match               - echoed candidate equals target, qualified by res_valid
interface search_sequencer_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             cand_valid;
  logic [WIDTH-1:0] cand_value;
  logic [WIDTH-1:0] target_value;
  logic             res_valid;
  logic [WIDTH-1:0] res_value;
  logic             res_match;

  modport master (
    output cand_valid,
    output cand_value,
    output target_value,
    input  res_valid,
    input  res_value,
    input  res_match
  );

  modport slave (
    input  cand_valid,
    input  cand_value,
    input  target_value,
    output res_valid,
    output res_value,
    output res_match
  );

endinterface

// File: rtl/search_sequencer_state_fsm.sv
// search_state_fsm: state register and one-hot status decode.
//   clk_i, rst_i      - clock, asynchronous active-high reset
//   enable_i          - 1 = search, 0 = pause
//   exhausted_i       - last candidate already issued
//   done_i            - exhausted and outstanding count reaches zero this cycle
//   match_i           - accepted result matched the target this cycle
//   warm_done_i       - warm-up counter expired
//   state_o           - current state
//   enter_warm_o      - PAUSED -> WARMING transition happens at the next edge
//   status_*_o        - one-hot state flags
module search_state_fsm
  import search_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   enable_i,
  input  logic   exhausted_i,
  input  logic   done_i,
  input  logic   match_i,
  input  logic   warm_done_i,
  output state_e state_o,
  output logic   enter_warm_o,
  output logic   status_paused_o,
  output logic   status_running_o,
  output logic   status_warming_o,
  output logic   status_found_o,
  output logic   status_done_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_PAUSED;
    else       state_q <= state_d;
  end

  // FOUND and DONE are terminal; a match outranks the drain condition.
  always_comb begin
    state_d      = state_q;
    enter_warm_o = 1'b0;
    if (state_q != ST_FOUND && state_q != ST_DONE) begin
      if (match_i) begin
        state_d = ST_FOUND;
      end else if (done_i) begin
        state_d = ST_DONE;
      end else if (state_q == ST_PAUSED) begin
        if (enable_i && !exhausted_i) begin
          state_d      = ST_WARMING;
          enter_warm_o = 1'b1;
        end
      end else if (!enable_i) begin
        state_d = ST_PAUSED;
      end else if (state_q == ST_WARMING && warm_done_i) begin
        state_d = ST_RUNNING;
      end
    end
  end

  always_comb begin
    state_o          = state_q;
    status_paused_o  = (state_q == ST_PAUSED);
    status_running_o = (state_q == ST_RUNNING);
    status_warming_o = (state_q == ST_WARMING);
    status_found_o   = (state_q == ST_FOUND);
    status_done_o    = (state_q == ST_DONE);
  end

endmodule

// File: rtl/search_sequencer.sv
// search_sequencer: issues candidates 0..LIMIT into a fixed-latency hash
// pipeline and stops on the first matching result or once all issued
// candidates have drained.
//   CLK, CPU_RESETN    - clock, asynchronous active-high reset (1 = in reset)
//   enable_switch      - 1 = search, 0 = pause
//   target_switch      - target selector, latched on first start after reset
//   pipe (master)      - candidate/result bus plus latched target
//   found_value        - matching candidate
//   status_*           - one-hot state flags
module search_sequencer
  import search_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      PIPE_DEPTH = PIPE_DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] LIMIT      = '1
) (
  input  logic                CLK,
  input  logic                CPU_RESETN,
  input  logic                enable_switch,
  input  logic [3:0]          target_switch,
  search_sequencer_if.master  pipe,
  output logic [WIDTH-1:0]    found_value,
  output logic                status_paused,
  output logic                status_running,
  output logic                status_warming,
  output logic                status_found,
  output logic                status_done
);

  localparam int unsigned OUT_W = $clog2(PIPE_DEPTH + 2) + 1;

  logic [WIDTH-1:0]  cand_q, cand_d;
  logic              exh_q, exh_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [WIDTH-1:0]  tgt_q, tgt_d;
  logic              lat_q, lat_d;
  logic [WIDTH-1:0]  found_q, found_d;

  state_e state;
  logic   issue, accept, match, drained, enter_warm, warm_done;

  search_state_fsm u_fsm (
    .clk_i            (CLK),
    .rst_i            (CPU_RESETN),
    .enable_i         (enable_switch),
    .exhausted_i      (exh_q),
    .done_i           (drained),
    .match_i          (match),
    .warm_done_i      (warm_done),
    .state_o          (state),
    .enter_warm_o     (enter_warm),
    .status_paused_o  (status_paused),
    .status_running_o (status_running),
    .status_warming_o (status_warming),
    .status_found_o   (status_found),
    .status_done_o    (status_done)
  );

  always_comb begin
    issue   = (state == ST_WARMING || state == ST_RUNNING) && !exh_q;
    // Results with nothing outstanding, or after a terminal state, are dropped.
    accept  = pipe.res_valid && (out_q != '0) && state != ST_FOUND && state != ST_DONE;
    match   = accept && pipe.res_match;
    out_d   = out_q + OUT_W'(issue) - OUT_W'(accept);
    drained = exh_q && (out_d == '0);

    // cand_value saturates at LIMIT; exh marks that LIMIT itself went out.
    cand_d = cand_q;
    exh_d  = exh_q;
    if (issue) begin
      if (cand_q == LIMIT) exh_d  = 1'b1;
      else                 cand_d = cand_q + WIDTH'(1);
    end

    warm_done = (warm_q == '0);
    warm_d    = warm_q;
    if (enter_warm)                           warm_d = WARM_W'(PIPE_DEPTH - 1);
    else if (state == ST_WARMING && !warm_done) warm_d = warm_q - WARM_W'(1);

    tgt_d = tgt_q;
    lat_d = lat_q;
    if (enter_warm && !lat_q) begin
      tgt_d = WIDTH'(decode_target(target_switch));
      lat_d = 1'b1;
    end

    found_d = found_q;
    if (match) found_d = pipe.res_value;
  end

  always_ff @(posedge CLK or posedge CPU_RESETN) begin
    if (CPU_RESETN) begin
      cand_q  <= '0;
      exh_q   <= 1'b0;
      out_q   <= '0;
      warm_q  <= '0;
      tgt_q   <= '0;
      lat_q   <= 1'b0;
      found_q <= '0;
    end else begin
      cand_q  <= cand_d;
      exh_q   <= exh_d;
      out_q   <= out_d;
      warm_q  <= warm_d;
      tgt_q   <= tgt_d;
      lat_q   <= lat_d;
      found_q <= found_d;
    end
  end

  assign pipe.cand_valid   = issue;
  assign pipe.cand_value   = cand_q;
  assign pipe.target_value = tgt_q;
  assign found_value       = found_q;

endmodule

// File: tb/tb_search_sequencer.sv
// Three sequencers (LIMIT = all-ones, 15, 0x10) share one stimulus stream.
// Each has its own 4-stage echo pipeline and a cycle-level reference model.
module tb_search_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned PD = 4;
  localparam int          NI = 3;

  logic         CLK           = 1'b0;
  logic         CPU_RESETN    = 1'b1;
  logic         enable_switch = 1'b0;
  logic [3:0]   target_switch = 4'd0;
  logic         inj_valid     = 1'b0;
  logic [W-1:0] inj_value     = '0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned  t;
    logic [W-1:0] v;
  } issue_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] spec_target(input logic [3:0] sel);
    int unsigned s;
    s = sel;
    if (s >= 10) return {W{1'b1}};
    if (s <= 2)  return W'(s);
    return W'(1) << (4 * (s - 2));
  endfunction

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam logic [W-1:0] LIM = (g == 0) ? {W{1'b1}} : (g == 1) ? W'(15) : W'(16);

    search_sequencer_if #(.WIDTH(W)) bus ();
    logic [4:0]   flags;  // {paused, running, warming, found, done}
    logic [W-1:0] fval;

    search_sequencer #(.WIDTH(W), .PIPE_DEPTH(PD), .LIMIT(LIM)) dut (
      .CLK            (CLK),
      .CPU_RESETN     (CPU_RESETN),
      .enable_switch  (enable_switch),
      .target_switch  (target_switch),
      .pipe           (bus.master),
      .found_value    (fval),
      .status_paused  (flags[4]),
      .status_running (flags[3]),
      .status_warming (flags[2]),
      .status_found   (flags[1]),
      .status_done    (flags[0])
    );

    // Echo pipeline: candidate returns PD cycles after issue.
    logic [PD-1:0] pv;
    logic [W-1:0]  pval [PD];
    always @(posedge CLK or posedge CPU_RESETN) begin
      if (CPU_RESETN) begin
        pv <= '0;
        for (int i = 0; i < PD; i++) pval[i] <= '0;
      end else begin
        pv      <= {pv[PD-2:0], bus.cand_valid};
        pval[0] <= bus.cand_value;
        for (int i = 1; i < PD; i++) pval[i] <= pval[i-1];
      end
    end
    assign bus.res_valid = pv[PD-1] | inj_valid;
    assign bus.res_value = pv[PD-1] ? pval[PD-1] : inj_value;
    assign bus.res_match = (bus.res_value == bus.target_value);

    // Reference model. ms: 0 paused, 1 running, 2 warming, 3 found, 4 done.
    int unsigned  cyc, ms, mw, mout;
    logic [W-1:0] mcand, mtgt, mfound;
    bit           mex, mlat;
    issue_t       q[$];

    always @(posedge CLK or posedge CPU_RESETN) begin : model
      bit           iss, have, acc, hit;
      logic [W-1:0] rv;
      int unsigned  nout;
      if (CPU_RESETN) begin
        ms = 0; mw = 0; mout = 0; cyc = 0;
        mcand = '0; mtgt = '0; mfound = '0; mex = 0; mlat = 0;
        q.delete();
      end else begin
        iss  = (ms == 1 || ms == 2) && !mex;
        have = 0;
        rv   = '0;
        if (q.size() > 0 && q[0].t + PD == cyc) begin
          have = 1;
          rv   = q[0].v;
          q.delete(0);
        end else if (inj_valid) begin
          have = 1;
          rv   = inj_value;
        end
        acc = have && ms != 3 && ms != 4 && mout > 0;
        hit = acc && (rv == mtgt);
        if (iss) q.push_back(issue_t'{t: cyc, v: mcand});
        nout = mout + (iss ? 1 : 0) - (acc ? 1 : 0);
        if (ms == 3 || ms == 4) begin
        end else if (hit) begin
          ms = 3; mfound = rv;
        end else if (mex && nout == 0) begin
          ms = 4;
        end else if (ms == 0) begin
          if (enable_switch && !mex) begin
            ms = 2; mw = PD;
            if (!mlat) begin mtgt = spec_target(target_switch); mlat = 1; end
          end
        end else if (!enable_switch) begin
          ms = 0;
        end else if (ms == 2) begin
          mw = mw - 1;
          if (mw == 0) ms = 1;
        end
        mout = nout;
        if (iss) begin
          if (mcand == LIM) mex = 1;
          else              mcand = mcand + 1;
        end
        cyc = cyc + 1;
      end
    end

    always @(negedge CLK) begin : compare
      logic [4:0] ef;
      logic       ecv;
      ef  = 5'b10000 >> ms;
      ecv = (ms == 1 || ms == 2) && !mex;
      chk($sformatf("i%0d flags", g),        W'(flags),          W'(ef));
      chk($sformatf("i%0d cand_valid", g),   W'(bus.cand_valid), W'(ecv));
      chk($sformatf("i%0d cand_value", g),   bus.cand_value,     mcand);
      chk($sformatf("i%0d target_value", g), bus.target_value,   mtgt);
      chk($sformatf("i%0d found_value", g),  fval,               mfound);
    end
  end

  localparam logic [4:0] F_P = 5'b10000, F_R = 5'b01000, F_W = 5'b00100,
                         F_F = 5'b00010, F_D = 5'b00001;

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Leaves the bench mid-cycle 0: the next edge is the first one out of reset.
  task automatic do_reset(input logic [3:0] sel, input logic en);
    @(negedge CLK);
    #1 CPU_RESETN = 1'b1;
    enable_switch = 1'b0;
    cycles(2);
    target_switch = sel;
    enable_switch = en;
    CPU_RESETN    = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cycles(2);
    chk("rst flags", W'(inst[0].flags), W'(F_P));
    chk("rst cand_valid", W'(inst[0].bus.cand_valid), '0);
    chk("rst cand_value", inst[0].bus.cand_value, '0);
    chk("rst target", inst[0].bus.target_value, '0);
    chk("rst found", inst[0].fval, '0);

    // Stray result with nothing outstanding (it would match target 0).
    do_reset(4'd0, 1'b0);
    inj_valid = 1'b1;
    inj_value = '0;
    cycles(1);
    inj_valid = 1'b0;
    cycles(1);
    chk("stray flags", W'(inst[0].flags), W'(F_P));
    chk("stray found", inst[0].fval, '0);

    // Scenario 1: target 0x100, later selector changes ignored.
    do_reset(4'd4, 1'b1);
    cycles(1);
    chk("s1 warm flags", W'(inst[0].flags), W'(F_W));
    chk("s1 first cand", inst[0].bus.cand_value, '0);
    chk("s1 first valid", W'(inst[0].bus.cand_valid), W'(1));
    target_switch = 4'd0;
    cycles(3);
    chk("s1 warm last", W'(inst[0].flags), W'(F_W));
    chk("s1 cand 3", inst[0].bus.cand_value, W'(3));
    cycles(1);
    chk("s1 running", W'(inst[0].flags), W'(F_R));
    chk("s1 cand 4", inst[0].bus.cand_value, W'(4));
    chk("s1 target", inst[0].bus.target_value, W'(32'h100));
    cycles(15);
    chk("s1 l15 not done", W'(inst[1].flags), W'(F_R));
    cycles(1);
    chk("s1 l15 done", W'(inst[1].flags), W'(F_D));
    chk("s1 l15 held cand", inst[1].bus.cand_value, W'(15));
    chk("s1 l16 running", W'(inst[2].flags), W'(F_R));
    cycles(1);
    chk("s1 l16 done", W'(inst[2].flags), W'(F_D));
    cycles(239);
    chk("s1 pre-found", W'(inst[0].flags), W'(F_R));
    chk("s1 result strobe", W'(inst[0].bus.res_valid), W'(1));
    cycles(1);
    chk("s1 found flags", W'(inst[0].flags), W'(F_F));
    chk("s1 found value", inst[0].fval, W'(32'h100));
    chk("s1 found valid", W'(inst[0].bus.cand_valid), '0);
    enable_switch = 1'b0;
    cycles(3);
    chk("s1 found sticky", W'(inst[0].flags), W'(F_F));

    // Scenario 2: pause after candidate 9, resume at 10.
    do_reset(4'd4, 1'b1);
    cycles(10);
    chk("s2 cand 9", inst[0].bus.cand_value, W'(9));
    enable_switch = 1'b0;
    cycles(1);
    chk("s2 paused", W'(inst[0].flags), W'(F_P));
    chk("s2 held 10", inst[0].bus.cand_value, W'(10));
    chk("s2 paused valid", W'(inst[0].bus.cand_valid), '0);
    cycles(5);
    enable_switch = 1'b1;
    cycles(1);
    chk("s2 rewarm", W'(inst[0].flags), W'(F_W));
    chk("s2 resume 10", inst[0].bus.cand_value, W'(10));
    cycles(4);
    chk("s2 rerun", W'(inst[0].flags), W'(F_R));
    chk("s2 cand 14", inst[0].bus.cand_value, W'(14));
    cycles(5);
    chk("s2 l15 running", W'(inst[1].flags), W'(F_R));
    cycles(1);
    chk("s2 l15 done", W'(inst[1].flags), W'(F_D));

    // Scenario 3: unreachable target with LIMIT 15.
    do_reset(4'd15, 1'b1);
    cycles(17);
    chk("s3 exhausted flags", W'(inst[1].flags), W'(F_R));
    chk("s3 exhausted valid", W'(inst[1].bus.cand_valid), '0);
    cycles(3);
    chk("s3 draining", W'(inst[1].flags), W'(F_R));
    cycles(1);
    chk("s3 done", W'(inst[1].flags), W'(F_D));
    chk("s3 found zero", inst[1].fval, '0);
    chk("s3 target ones", inst[1].bus.target_value, {W{1'b1}});
    enable_switch = 1'b0;
    cycles(2);
    chk("s3 done sticky", W'(inst[1].flags), W'(F_D));

    // Scenario 4: last candidate matches as the pipeline drains.
    do_reset(4'd3, 1'b1);
    cycles(21);
    chk("s4 pre", W'(inst[2].flags), W'(F_R));
    cycles(1);
    chk("s4 found wins", W'(inst[2].flags), W'(F_F));
    chk("s4 found value", inst[2].fval, W'(32'h10));
    chk("s4 l15 done", W'(inst[1].flags), W'(F_D));

    // Scenario 5: reset pulse between edges while running.
    do_reset(4'd4, 1'b1);
    cycles(30);
    #1 CPU_RESETN = 1'b1;
    #1;
    chk("s5 flags", W'(inst[0].flags), W'(F_P));
    chk("s5 valid", W'(inst[0].bus.cand_valid), '0);
    chk("s5 cand", inst[0].bus.cand_value, '0);
    chk("s5 target", inst[0].bus.target_value, '0);
    chk("s5 found", inst[0].fval, '0);
    target_switch = 4'd5;
    #1 CPU_RESETN = 1'b0;
    cycles(1);
    chk("s5 rewarm", W'(inst[0].flags), W'(F_W));
    chk("s5 restart 0", inst[0].bus.cand_value, '0);
    chk("s5 relatch", inst[0].bus.target_value, W'(32'h1000));
    cycles(1);
    chk("s5 cand 1", inst[0].bus.cand_value, W'(1));

    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
